// File: rtl/axis_packet_buffer.sv
// axis_packet_buffer: single-clock AXI4-Stream buffer with DEPTH words of
// memory plus one output register, so it holds DEPTH+1 words in total.
// It runs in one of two modes:
//   PACKET_MODE=0 (cut-through): any stored word is forwarded as soon as possible.
//   PACKET_MODE=1 (store-and-forward): a packet is held until its tlast word
//     has been stored. A packet larger than the memory is released once the
//     memory is full, so an oversize packet cannot deadlock the buffer.
// Optional feature: define AXIS_BUF_STATUS_EN to add the buf_level and
// buf_pkt_cnt status outputs. Without the macro, those ports and their logic
// do not exist.
//
// Handshake rule on both sides: a word moves on a rising edge where tvalid and
// tready are both high. Once m01_axis_tvalid is asserted, it stays high and
// m01_axis_tdata/tstrb/tlast hold stable until the consumer takes the word.
// The producer may present data at any time; it is taken only when
// s01_axis_tready is high.
// rd_state_dbg exposes the read FSM state (0 = RD_IDLE, 1 = RD_PKT).
module axis_packet_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int PACKET_MODE = 0
) (
  input  logic                      axis_aclk,
  input  logic                      axis_aresetn,
  input  logic [DATA_WIDTH-1:0]     s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s01_axis_tstrb,
  input  logic                      s01_axis_tvalid,
  input  logic                      s01_axis_tlast,
  output logic                      s01_axis_tready,
  output logic [DATA_WIDTH-1:0]     m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m01_axis_tstrb,
  output logic                      m01_axis_tvalid,
  output logic                      m01_axis_tlast,
  input  logic                      m01_axis_tready,
  output logic                      rd_state_dbg
`ifdef AXIS_BUF_STATUS_EN
  ,
  output logic [ADDR_WIDTH+1:0]     buf_level,
  output logic [ADDR_WIDTH:0]       buf_pkt_cnt
`endif
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int ENTRY_W = 1 + STRB_W + DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_PKT  = 1'b1
  } rd_state_t;

  // Each memory entry is {tlast, tstrb, tdata}.
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] pkt_cnt;
  rd_state_t           rd_state;
  rd_state_t           rd_state_n;

  logic                empty;
  logic                full;
  logic                wr_en;
  logic                eligible;
  logic                load;
  logic [ENTRY_W-1:0]  rd_word;
  logic                rd_last;
  logic                pkt_inc;
  logic                pkt_dec;

  // The pointers wrap modulo 2*DEPTH. The extra MSB tells a full memory apart
  // from an empty one when the two addresses are equal.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  // s01_axis_tready comes only from the registered pointers and the reset
  // input. After a read from a full memory, tready rises one cycle later.
  assign s01_axis_tready = axis_aresetn && !full;
  assign wr_en           = s01_axis_tvalid && s01_axis_tready;

  assign rd_word = mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign rd_last = rd_word[ENTRY_W-1];

  // pkt_cnt counts the tlast words currently held in memory.
  assign pkt_inc = wr_en && s01_axis_tlast;
  assign pkt_dec = load && rd_last;

  assign rd_state_dbg = rd_state;

  // Memory write port. The contents need no reset because the pointers
  // decide which entries are valid.
  always_ff @(posedge axis_aclk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata};
    end
  end

  // Write pointer: advances on every accepted word.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer: advances whenever a word moves into the output register.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      rd_ptr <= '0;
    end else if (load) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Packet counter. If a tlast word is written and another is read in the
  // same cycle, the count does not change.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      pkt_cnt <= '0;
    end else begin
      case ({pkt_inc, pkt_dec})
        2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
        2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Read FSM state register.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      rd_state <= RD_IDLE;
    end else begin
      rd_state <= rd_state_n;
    end
  end

  // Read FSM next state and read eligibility. In RD_IDLE the buffer is at a
  // packet boundary. In packet mode it waits there until a whole packet is
  // stored, or until the memory is full, which releases an oversize packet.
  // In RD_PKT, a packet is partly sent, so the rest of it streams out freely.
  always_comb begin
    rd_state_n = rd_state;
    eligible   = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (PACKET_MODE == 0) begin
          eligible = !empty;
        end else begin
          eligible = !empty && ((pkt_cnt != '0) || full);
        end
      end
      RD_PKT: begin
        eligible = !empty;
      end
      default: begin
        eligible = 1'b0;
      end
    endcase
    load = eligible && (!m01_axis_tvalid || m01_axis_tready);
    if (load) begin
      rd_state_n = rd_last ? RD_IDLE : RD_PKT;
    end
  end

  // Output register. It loads when it is empty or being drained. It empties
  // on a consumer handshake when nothing new can be loaded. While a word is
  // stalled, the register keeps its value.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      m01_axis_tvalid <= 1'b0;
      m01_axis_tdata  <= '0;
      m01_axis_tstrb  <= '0;
      m01_axis_tlast  <= 1'b0;
    end else if (load) begin
      m01_axis_tvalid <= 1'b1;
      m01_axis_tdata  <= rd_word[DATA_WIDTH-1:0];
      m01_axis_tstrb  <= rd_word[DATA_WIDTH +: STRB_W];
      m01_axis_tlast  <= rd_last;
    end else if (m01_axis_tready) begin
      m01_axis_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_BUF_STATUS_EN
  logic [ADDR_WIDTH:0] mem_level;

  // Occupancy comes from registered state only, so each value appears on the
  // cycle after the handshake that changed it.
  always_comb begin
    mem_level   = wr_ptr - rd_ptr;
    buf_level   = {1'b0, mem_level} + {{(ADDR_WIDTH+1){1'b0}}, m01_axis_tvalid};
    buf_pkt_cnt = pkt_cnt;
  end
`endif

endmodule
